// File: rtl/openram_scan_master_if.sv
// Request/response bus between the host logic and openram_scan_master.
// master = host side that issues packets, slave = the scan engine serving them.
interface openram_scan_master_if #(
    parameter int PKT_W = 112
);
    logic             req_valid;
    logic             req_ready;
    logic [PKT_W-1:0] req_pkt;
    logic             resp_valid;
    logic             resp_ready;
    logic [PKT_W-1:0] resp_pkt;
    logic             resp_err;

    modport master (
        output req_valid, req_pkt, resp_ready,
        input  req_ready, resp_valid, resp_pkt, resp_err
    );

    modport slave (
        input  req_valid, req_pkt, resp_ready,
        output req_ready, resp_valid, resp_pkt, resp_err
    );
endinterface

// File: rtl/openram_scan_master.sv
// Host-side driver for the OpenRAM testchip GPIO scan chain: shift a request in, run one
// SRAM cycle, capture and shift the chain back out. Optional macro: SCAN_READBACK_CMP_EN.
module openram_scan_master #(
    parameter int PKT_W   = 112,
    parameter int CLK_DIV = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  resetn,
    openram_scan_master_if.slave  bus,
    output logic                  scan_clk_o,
    output logic                  scan_data_o,
    output logic                  sram_clk_o,
    output logic                  sram_load_o,
    input  logic                  scan_out_i
);
    localparam int BW = $clog2(PKT_W);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT_IN, S_LOAD, S_CAPTURE, S_SHIFT_OUT, S_RESP
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       div_cnt;
    logic             hi;
    logic [BW-1:0]    bit_cnt;
    logic [PKT_W-1:0] sr;
    logic             scan_data_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [PKT_W-1:0] resp_pkt_q;

    logic in_pulse, ph_end, pulse_done, accept;

    assign in_pulse   = (state == S_SHIFT_IN) || (state == S_LOAD) ||
                        (state == S_CAPTURE)  || (state == S_SHIFT_OUT);
    assign ph_end     = (div_cnt == 8'(CLK_DIV - 1));
    // A pulse ends on the last cycle of its high phase; scan_out_i is sampled here too.
    assign pulse_done = in_pulse && ph_end && hi;
    assign accept     = (state == S_IDLE) && req_ready_q && bus.req_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (accept) state_nxt = S_SHIFT_IN;
            S_SHIFT_IN:  if (pulse_done && bit_cnt == '0) state_nxt = S_LOAD;
            S_LOAD:      if (pulse_done) state_nxt = S_CAPTURE;
            S_CAPTURE:   if (pulse_done) state_nxt = S_SHIFT_OUT;
            S_SHIFT_OUT: if (pulse_done && bit_cnt == '0) state_nxt = S_RESP;
            S_RESP:      if (resp_valid_q && bus.resp_ready) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            state        <= S_IDLE;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_pkt_q   <= '0;
            div_cnt      <= '0;
            hi           <= 1'b0;
            bit_cnt      <= '0;
            sr           <= '0;
            scan_data_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_ready_q <= (state_nxt == S_IDLE);

            if (in_pulse && !ph_end) div_cnt <= div_cnt + 8'd1;
            else                     div_cnt <= '0;

            if (in_pulse && ph_end) hi <= ~hi;
            else if (!in_pulse)     hi <= 1'b0;

            case (state)
                S_IDLE: if (accept) begin
                    sr          <= bus.req_pkt;
                    bit_cnt     <= BW'(PKT_W - 1);
                    scan_data_q <= bus.req_pkt[PKT_W-1];
                end
                S_SHIFT_IN: if (pulse_done) begin
                    if (bit_cnt != '0) begin
                        sr          <= {sr[PKT_W-2:0], 1'b0};
                        scan_data_q <= sr[PKT_W-2];
                        bit_cnt     <= bit_cnt - 1'b1;
                    end else begin
                        scan_data_q <= 1'b0;
                    end
                end
                S_CAPTURE: if (pulse_done) bit_cnt <= BW'(PKT_W - 1);
                S_SHIFT_OUT: if (pulse_done) begin
                    sr <= {sr[PKT_W-2:0], scan_out_i};
                    if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
                end
                S_RESP: begin
                    if (!resp_valid_q) begin
                        resp_valid_q <= 1'b1;
                        resp_pkt_q   <= sr;
                    end else if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // hi is cleared on every state change, so the two clocks can never overlap.
    assign scan_clk_o  = hi && (state != S_LOAD);
    assign sram_clk_o  = hi && (state == S_LOAD);
    assign sram_load_o = (state == S_LOAD) || (state == S_CAPTURE);
    assign scan_data_o = scan_data_q;

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_pkt   = resp_pkt_q;

`ifdef SCAN_READBACK_CMP_EN
    // dout fields [63:0] legitimately change across the SRAM cycle; everything else must echo.
    localparam logic [PKT_W-1:0] CMP_MASK = {PKT_W{1'b1}} << 64;

    logic [PKT_W-1:0] shadow;
    logic             err_q;

    always_ff @(posedge wb_clk_i) begin
        if (!resetn) begin
            shadow <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) shadow <= bus.req_pkt;
            if (state == S_RESP && !resp_valid_q)
                err_q <= |((sr ^ shadow) & CMP_MASK);
            else if (resp_valid_q && bus.resp_ready)
                err_q <= 1'b0;
        end
    end

    assign bus.resp_err = err_q;
`else
    assign bus.resp_err = 1'b0;
`endif
endmodule

// File: tb/tb_openram_scan_master.sv
// Directed bench for openram_scan_master with a behavioural 112-bit testchip chain model.
module tb_openram_scan_master;
    localparam int P = 112;
`ifdef SCAN_READBACK_CMP_EN
    localparam logic CMP = 1'b1;
`else
    localparam logic CMP = 1'b0;
`endif
    localparam logic [P-1:0] HI_MASK = {P{1'b1}} << 64;

    logic wb_clk_i = 1'b0;
    logic resetn   = 1'b0;
    logic scan_clk_o, scan_data_o, sram_clk_o, sram_load_o, scan_out_i;

    openram_scan_master_if #(.PKT_W(P)) bus ();

    openram_scan_master #(.PKT_W(P), .CLK_DIV(1)) dut (
        .wb_clk_i    (wb_clk_i),
        .resetn      (resetn),
        .bus         (bus),
        .scan_clk_o  (scan_clk_o),
        .scan_data_o (scan_data_o),
        .sram_clk_o  (sram_clk_o),
        .sram_load_o (sram_load_o),
        .scan_out_i  (scan_out_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int cyc = 0;
    always @(posedge wb_clk_i) cyc++;

    // Chain model: parallel load on capture, otherwise shift with gpio_out updated on the rising edge.
    logic [P-1:0] chain = '0;
    logic [P-1:0] cap_val = '0;
    logic [P-1:0] flip_vec = '0;
    logic         keep_hi = 1'b0;
    logic         chain_out = 1'b0;
    logic         rec [0:255];
    int           nrise = 0, n_sram = 0, rise_at_sram = -1;
    logic         load_at_sram = 1'b0;
    logic         overlap = 1'b0;

    assign scan_out_i = chain_out;

    always @(posedge scan_clk_o) begin
        if (sram_load_o) begin
            chain <= (keep_hi ? ((chain & HI_MASK) | (cap_val & ~HI_MASK)) : cap_val) ^ flip_vec;
        end else begin
            chain_out <= chain[P-1];
            chain     <= {chain[P-2:0], scan_data_o};
            if (nrise < 256) rec[nrise] = scan_data_o;
            nrise++;
        end
    end

    always @(posedge sram_clk_o) begin
        n_sram++;
        rise_at_sram = nrise;
        load_at_sram = sram_load_o;
    end

    always @(negedge wb_clk_i) if (scan_clk_o && sram_clk_o) overlap = 1'b1;

    int n_pass = 0, n_tot = 0;
    int acc = 0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chkp(input string tag, input logic [P-1:0] obs, input logic [P-1:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Called at a negedge; leaves at the negedge after the accept edge.
    task automatic send(input logic [P-1:0] pkt);
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge wb_clk_i);
        chk1("req_ready_before_send", bus.req_ready, 1'b1);
        bus.req_pkt   = pkt;
        bus.req_valid = 1'b1;
        acc = cyc + 1;
        @(negedge wb_clk_i);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        for (int i = 0; i < 3000 && !bus.resp_valid; i++) @(negedge wb_clk_i);
        chk1("resp_valid_timeout", bus.resp_valid, 1'b1);
        lat = cyc - acc;
    endtask

    initial begin
        logic [P-1:0] a5, p2, exp2, held;
        logic         any1, stable, rdy_low, vld_high, saw_vld;
        int           lat;

        a5   = {14{8'hA5}};
        p2   = 112'h0123_4567_89AB_CDEF_FEDC_BA98_7654;
        exp2 = 112'h0123_4567_89AB_DEAD_BEEF_0BAD_F00D;

        bus.req_valid  = 1'b1;
        bus.req_pkt    = '0;
        bus.resp_ready = 1'b0;

        // Reset with req_valid asserted
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk1("rst_req_ready", bus.req_ready, 1'b0);
        chk1("rst_resp_valid", bus.resp_valid, 1'b0);
        chkp("rst_resp_pkt", bus.resp_pkt, '0);
        chk1("rst_resp_err", bus.resp_err, 1'b0);
        chk1("rst_scan_clk", scan_clk_o, 1'b0);
        chk1("rst_scan_data", scan_data_o, 1'b0);
        chk1("rst_sram_clk", sram_clk_o, 1'b0);
        chk1("rst_sram_load", sram_load_o, 1'b0);
        @(negedge wb_clk_i);
        resetn        = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge wb_clk_i);
        #1;
        chk1("req_ready_after_release", bus.req_ready, 1'b1);
        @(negedge wb_clk_i);

        // Request 112'h1, chain captures A5.. ; response held off for 10 cycles
        cap_val = a5; keep_hi = 1'b0; flip_vec = '0;
        nrise = 0; n_sram = 0; rise_at_sram = -1;
        send(112'h1);
        wait_resp(lat);
        chki("latency_a5", lat, 453);
        chkp("resp_pkt_a5", bus.resp_pkt, a5);
        chk1("resp_err_a5", bus.resp_err, CMP);
        chki("scan_rises_before_sram", rise_at_sram, 112);
        chk1("sram_load_at_sram_clk", load_at_sram, 1'b1);
        chki("sram_pulses", n_sram, 1);
        any1 = 1'b0;
        for (int i = 0; i < 111; i++) any1 |= rec[i];
        chk1("data_first_111_zero", any1, 1'b0);
        chk1("data_bit_112_one", rec[111], 1'b1);
        chki("total_scan_rises", nrise, 224);

        held = bus.resp_pkt; stable = 1'b1; rdy_low = 1'b1; vld_high = 1'b1;
        repeat (10) begin
            @(negedge wb_clk_i);
            stable   &= (bus.resp_pkt === held);
            rdy_low  &= (bus.req_ready === 1'b0);
            vld_high &= (bus.resp_valid === 1'b1);
        end
        chk1("hold_pkt_stable", stable, 1'b1);
        chk1("hold_req_ready_low", rdy_low, 1'b1);
        chk1("hold_resp_valid", vld_high, 1'b1);
        bus.resp_ready = 1'b1;
        @(posedge wb_clk_i);
        #1;
        chk1("handshake_resp_valid_low", bus.resp_valid, 1'b0);
        chk1("handshake_req_ready", bus.req_ready, 1'b1);
        @(negedge wb_clk_i);
        bus.resp_ready = 1'b0;

        // Reset pulse during shift-in pulse 50
        nrise = 0; n_sram = 0;
        send(p2);
        for (int i = 0; i < 500 && nrise < 50; i++) @(negedge wb_clk_i);
        chki("reach_pulse_50", nrise, 50);
        resetn = 1'b0;
        @(posedge wb_clk_i);
        #1;
        chk1("abort_scan_clk", scan_clk_o, 1'b0);
        chk1("abort_sram_clk", sram_clk_o, 1'b0);
        chk1("abort_sram_load", sram_load_o, 1'b0);
        @(negedge wb_clk_i);
        resetn = 1'b1;
        saw_vld = 1'b0;
        repeat (600) begin
            @(negedge wb_clk_i);
            saw_vld |= bus.resp_valid;
        end
        chk1("abort_no_resp", saw_vld, 1'b0);
        chki("abort_no_sram_pulse", n_sram, 0);

        // Normal request after abort: echo upper fields, SRAM data in [63:0], ready pre-asserted
        cap_val = {48'h0, 64'hDEAD_BEEF_0BAD_F00D}; keep_hi = 1'b1; flip_vec = '0;
        bus.resp_ready = 1'b1;
        send(p2);
        wait_resp(lat);
        chki("latency_p2", lat, 453);
        chkp("resp_pkt_p2", bus.resp_pkt, exp2);
        chk1("resp_err_clean", bus.resp_err, 1'b0);
        @(negedge wb_clk_i);
        chk1("one_cycle_resp", bus.resp_valid, 1'b0);

        // Chain flips bit 100
        flip_vec = '0; flip_vec[100] = 1'b1;
        send(p2);
        wait_resp(lat);
        chkp("resp_pkt_flip", bus.resp_pkt, 112'h0133_4567_89AB_DEAD_BEEF_0BAD_F00D);
        chk1("resp_err_flip", bus.resp_err, CMP);
        @(negedge wb_clk_i);
        chk1("flip_resp_done", bus.resp_valid, 1'b0);
        chk1("err_cleared", bus.resp_err, 1'b0);

        chk1("clocks_never_overlap", overlap, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
